// File: rtl/mw_writeback_stage.sv
// MEM/WB pipeline register and writeback datapath: load extraction/extension,
// writeback source select, GRF write port and W-stage forwarding. Option: MISALIGN_CHECK_EN.
module mw_writeback_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        flush,
   input  logic        m_valid,
   input  logic [31:0] m_pc,
   input  logic        m_reg_we,
   input  logic [4:0]  m_reg_wa,
   input  logic [1:0]  m_wd_sel,
   input  logic [2:0]  m_load_type,
   input  logic [31:0] m_alu_result,
   input  logic [31:0] m_mem_rdata,
   output logic        grf_we,
   output logic [4:0]  grf_wa,
   output logic [31:0] grf_wd,
   output logic [31:0] w_pc,
   output logic        w_fwd_valid,
   output logic        w_exc
);

   localparam logic [1:0] WD_ALU = 2'd0;
   localparam logic [1:0] WD_MEM = 2'd1;
   localparam logic [1:0] WD_PC8 = 2'd2;

   localparam logic [2:0] LT_LW  = 3'd0;
   localparam logic [2:0] LT_LH  = 3'd1;
   localparam logic [2:0] LT_LHU = 3'd2;
   localparam logic [2:0] LT_LB  = 3'd3;
   localparam logic [2:0] LT_LBU = 3'd4;

   // W register fields
   logic        valid_q,     valid_d;
   logic        reg_we_q,    reg_we_d;
   logic [4:0]  wa_q,        wa_d;
   logic [1:0]  wd_sel_q,    wd_sel_d;
   logic [2:0]  load_type_q, load_type_d;
   logic [31:0] alu_q,       alu_d;
   logic [31:0] rdata_q,     rdata_d;
   logic [31:0] pc_q,        pc_d;

   // Flush loads the same bubble as reset; en=0 holds every field.
   always_comb begin
      valid_d     = valid_q;
      reg_we_d    = reg_we_q;
      wa_d        = wa_q;
      wd_sel_d    = wd_sel_q;
      load_type_d = load_type_q;
      alu_d       = alu_q;
      rdata_d     = rdata_q;
      pc_d        = pc_q;
      if (flush) begin
         valid_d     = 1'b0;
         reg_we_d    = 1'b0;
         wa_d        = 5'd0;
         wd_sel_d    = WD_ALU;
         load_type_d = LT_LW;
         alu_d       = 32'd0;
         rdata_d     = 32'd0;
         pc_d        = RESET_PC;
      end else if (en) begin
         valid_d     = m_valid;
         reg_we_d    = m_reg_we;
         wa_d        = m_reg_wa;
         wd_sel_d    = m_wd_sel;
         load_type_d = m_load_type;
         alu_d       = m_alu_result;
         rdata_d     = m_mem_rdata;
         pc_d        = m_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         reg_we_q    <= 1'b0;
         wa_q        <= 5'd0;
         wd_sel_q    <= WD_ALU;
         load_type_q <= LT_LW;
         alu_q       <= 32'd0;
         rdata_q     <= 32'd0;
         pc_q        <= RESET_PC;
      end else begin
         valid_q     <= valid_d;
         reg_we_q    <= reg_we_d;
         wa_q        <= wa_d;
         wd_sel_q    <= wd_sel_d;
         load_type_q <= load_type_d;
         alu_q       <= alu_d;
         rdata_q     <= rdata_d;
         pc_q        <= pc_d;
      end
   end

   // Load extraction: everything below reads only the W register.
   logic [1:0]  off;
   logic [7:0]  byte_lane [4];
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign off = alu_q[1:0];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign byte_lane[gi] = rdata_q[8*gi +: 8];
      end
   endgenerate

   assign ld_byte = byte_lane[off];
   // Halfword select uses only off[1]; an odd offset is either trapped or ignored.
   assign ld_half = off[1] ? rdata_q[31:16] : rdata_q[15:0];

   always_comb begin
      ld_data = rdata_q;
      case (load_type_q)
         LT_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
         LT_LHU:  ld_data = {16'd0, ld_half};
         LT_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         LT_LBU:  ld_data = {24'd0, ld_byte};
         default: ld_data = rdata_q;
      endcase
   end

   always_comb begin
      grf_wd = alu_q;
      case (wd_sel_q)
         WD_MEM:  grf_wd = ld_data;
         WD_PC8:  grf_wd = pc_q + 32'd8;
         default: grf_wd = alu_q;
      endcase
   end

   logic exc_suppress;

`ifdef MISALIGN_CHECK_EN
   logic misaligned;

   always_comb begin
      misaligned = 1'b0;
      if (wd_sel_q == WD_MEM) begin
         case (load_type_q)
            LT_LH, LT_LHU: misaligned = off[0];
            LT_LB, LT_LBU: misaligned = 1'b0;
            default:       misaligned = (off != 2'b00);
         endcase
      end
   end

   assign w_exc        = valid_q & misaligned;
   assign exc_suppress = misaligned;
`else
   assign w_exc        = 1'b0;
   assign exc_suppress = 1'b0;
`endif

   // $0 never writes, so it can never appear on the forwarding bus.
   assign grf_we      = valid_q & reg_we_q & (wa_q != 5'd0) & ~exc_suppress;
   assign grf_wa      = wa_q;
   assign w_pc        = pc_q;
   assign w_fwd_valid = grf_we;

endmodule

// File: tb/tb_mw_writeback_stage.sv
// Self-checking bench for mw_writeback_stage: directed steps then random traffic
// compared against a transaction-level model of the W register.
module tb_mw_writeback_stage;

   logic        clk = 1'b0;
   logic        reset, en, flush;
   logic        m_valid, m_reg_we;
   logic [31:0] m_pc, m_alu_result, m_mem_rdata;
   logic [4:0]  m_reg_wa;
   logic [1:0]  m_wd_sel;
   logic [2:0]  m_load_type;
   logic        grf_we, w_fwd_valid, w_exc;
   logic [4:0]  grf_wa;
   logic [31:0] grf_wd, w_pc;

   int n_checks = 0;
   int n_fail   = 0;

   mw_writeback_stage dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .m_valid(m_valid), .m_pc(m_pc), .m_reg_we(m_reg_we), .m_reg_wa(m_reg_wa),
      .m_wd_sel(m_wd_sel), .m_load_type(m_load_type),
      .m_alu_result(m_alu_result), .m_mem_rdata(m_mem_rdata),
      .grf_we(grf_we), .grf_wa(grf_wa), .grf_wd(grf_wd), .w_pc(w_pc),
      .w_fwd_valid(w_fwd_valid), .w_exc(w_exc)
   );

   always #5 clk = ~clk;

   // Model: the instruction currently held in W, as a plain record.
   typedef struct {
      bit          valid, we;
      int unsigned wa, sel, lt;
      logic [31:0] alu, rdata, pc;
   } winstr_t;

   winstr_t w;

   function automatic winstr_t bubble();
      winstr_t b;
      b.valid = 0; b.we = 0; b.wa = 0; b.sel = 0; b.lt = 0;
      b.alu = 0; b.rdata = 0; b.pc = 32'h0000_3000;
      return b;
   endfunction

   function automatic logic [31:0] load_value(winstr_t x);
      int unsigned off;
      logic [31:0] b, h;
      off = x.alu % 4;
      b = (x.rdata >> (8 * off)) & 32'hFF;
      h = (off >= 2) ? (x.rdata >> 16) : (x.rdata & 32'hFFFF);
      case (x.lt)
         1: return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
         2: return h;
         3: return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
         4: return b;
         default: return x.rdata;
      endcase
   endfunction

   function automatic bit is_misaligned(winstr_t x);
`ifdef MISALIGN_CHECK_EN
      int unsigned off;
      off = x.alu % 4;
      if (x.sel != 1) return 0;
      if (x.lt == 1 || x.lt == 2) return (off % 2) == 1;
      if (x.lt == 3 || x.lt == 4) return 0;
      return off != 0;
`else
      return 0;
`endif
   endfunction

   function automatic logic [31:0] exp_wd(winstr_t x);
      if (x.sel == 1) return load_value(x);
      if (x.sel == 2) return x.pc + 32'd8;
      return x.alu;
   endfunction

   function automatic bit exp_we(winstr_t x);
      return x.valid && x.we && x.wa != 0 && !is_misaligned(x);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".we"},  {31'd0, grf_we}, {31'd0, exp_we(w)});
      check({tag, ".fwd"}, {31'd0, w_fwd_valid}, {31'd0, exp_we(w)});
      check({tag, ".wa"},  {27'd0, grf_wa}, w.wa);
      check({tag, ".wd"},  grf_wd, exp_wd(w));
      check({tag, ".pc"},  w_pc, w.pc);
      check({tag, ".exc"}, {31'd0, w_exc}, {31'd0, w.valid && is_misaligned(w)});
      $display("%s: we=%0d wa=%0d wd=%h pc=%h exc=%0d", tag, grf_we, grf_wa, grf_wd, w_pc, w_exc);
   endtask

   // Advance one clock; update the model with the inputs seen at the edge.
   task automatic tick();
      winstr_t n;
      @(posedge clk);
      if (reset || flush) w = bubble();
      else if (en) begin
         n.valid = m_valid; n.we = m_reg_we; n.wa = m_reg_wa; n.sel = m_wd_sel;
         n.lt = m_load_type; n.alu = m_alu_result; n.rdata = m_mem_rdata; n.pc = m_pc;
         w = n;
      end
      #1;
   endtask

   task automatic set_m(input bit v, input bit we, input int unsigned wa, input int unsigned sel,
                        input int unsigned lt, input logic [31:0] alu, input logic [31:0] rd,
                        input logic [31:0] pc);
      m_valid = v; m_reg_we = we; m_reg_wa = 5'(wa); m_wd_sel = 2'(sel);
      m_load_type = 3'(lt); m_alu_result = alu; m_mem_rdata = rd; m_pc = pc;
   endtask

   task automatic load_step(input string tag, input int unsigned lt, input int unsigned off,
                            input logic [31:0] expect_wd);
      set_m(1, 1, 9, 1, lt, 32'h0000_1000 + off, 32'h80FF_7F01, 32'h3008);
      tick();
      check(tag, grf_wd, expect_wd);
      check_model(tag);
   endtask

   initial begin
      w = bubble();
      reset = 1; en = 1; flush = 0;
      set_m(1, 1, 5, 0, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h4000);

      // Reset for two cycles, then hold with en=0.
      tick();
      tick();
      check("rst.we", {31'd0, grf_we}, 32'd0);
      check("rst.pc", w_pc, 32'h0000_3000);
      check("rst.wd", grf_wd, 32'd0);
      check_model("rst");
      reset = 0; en = 0;
      tick();
      check("rst_hold.pc", w_pc, 32'h0000_3000);
      check_model("rst_hold");

      // Plain ALU writeback.
      en = 1;
      set_m(1, 1, 8, 0, 0, 32'h1234_5678, 32'h0, 32'h3004);
      tick();
      check("alu.we", {31'd0, grf_we}, 32'd1);
      check("alu.wa", {27'd0, grf_wa}, 32'd8);
      check("alu.wd", grf_wd, 32'h1234_5678);
      check("alu.pc", w_pc, 32'h0000_3004);
      check_model("alu");

      // Load extraction and extension.
      load_step("lb_off2",  3, 2, 32'hFFFF_FFFF);
      load_step("lbu_off3", 4, 3, 32'h0000_0080);
      load_step("lh_off0",  1, 0, 32'h0000_7F01);
      load_step("lh_off2",  1, 2, 32'hFFFF_80FF);
      load_step("lhu_off2", 2, 2, 32'h0000_80FF);
      load_step("lb_off0",  3, 0, 32'h0000_0001);

      // PC+8 link, then the same to $0.
      set_m(1, 1, 31, 2, 0, 32'h0, 32'h0, 32'h3010);
      tick();
      check("link.wd", grf_wd, 32'h0000_3018);
      check("link.we", {31'd0, grf_we}, 32'd1);
      check_model("link");
      set_m(1, 1, 0, 2, 0, 32'h0, 32'h0, 32'h3010);
      tick();
      check("link0.we", {31'd0, grf_we}, 32'd0);
      check("link0.fwd", {31'd0, w_fwd_valid}, 32'd0);
      check_model("link0");

      // Flush overrides en, then the bubble holds for 3 cycles.
      set_m(1, 1, 7, 0, 0, 32'h5555_AAAA, 32'h0, 32'h3020);
      tick();
      flush = 1;
      set_m(1, 1, 6, 0, 0, 32'h1111_2222, 32'h0, 32'h3024);
      tick();
      check("flush.we", {31'd0, grf_we}, 32'd0);
      check("flush.pc", w_pc, 32'h0000_3000);
      check_model("flush");
      flush = 0; en = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("flush_hold.pc", w_pc, 32'h0000_3000);
         check_model("flush_hold");
      end

      // Misaligned LW.
      en = 1;
      set_m(1, 1, 10, 1, 0, 32'h0000_2002, 32'hA5A5_1234, 32'h3030);
      tick();
`ifdef MISALIGN_CHECK_EN
      check("lw_mis.exc", {31'd0, w_exc}, 32'd1);
      check("lw_mis.we", {31'd0, grf_we}, 32'd0);
`else
      check("lw_mis.exc", {31'd0, w_exc}, 32'd0);
      check("lw_mis.we", {31'd0, grf_we}, 32'd1);
      check("lw_mis.wd", grf_wd, 32'hA5A5_1234);
`endif
      check_model("lw_mis");

      // Mid-stream reset discards a valid W write.
      set_m(1, 1, 12, 0, 0, 32'h7777_0000, 32'h0, 32'h3040);
      tick();
      check("pre_rst.we", {31'd0, grf_we}, 32'd1);
      reset = 1;
      tick();
      check("mid_rst.we", {31'd0, grf_we}, 32'd0);
      reset = 0;
      tick();
      check_model("post_rst");

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 39) == 0);
         flush = ($urandom_range(0, 9) == 0);
         en    = ($urandom_range(0, 3) != 0);
         set_m($urandom_range(0, 1), $urandom_range(0, 1),
               ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 31),
               $urandom_range(0, 3), $urandom_range(0, 7),
               $urandom, $urandom, $urandom);
         tick();
         check_model($sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
